// File: rtl/random_engine_arbiter_if.sv
// Bundle of the request/response, seed and LFSR-datapath signals that the
// random-word arbiter exchanges with its clients and the serial LFSR.
interface random_engine_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int WORD_BITS = 16,
    parameter int SEED_BITS = 16
);
    logic [NUM_REQ-1:0]   req_val;
    logic [NUM_REQ-1:0]   req_rdy;
    logic [NUM_REQ-1:0]   resp_val;
    logic [NUM_REQ-1:0]   resp_rdy;
    logic [WORD_BITS-1:0] resp_msg;
    logic                 seed_val;
    logic                 seed_rdy;
    logic [SEED_BITS-1:0] seed_msg;
    logic                 active;
    logic                 lfsr_en;
    logic                 lfsr_load;
    logic [SEED_BITS-1:0] lfsr_seed;
    logic                 lfsr_bit;

    modport master (
        output req_val, resp_rdy, seed_val, seed_msg, lfsr_bit,
        input  req_rdy, resp_val, resp_msg, seed_rdy, active,
               lfsr_en, lfsr_load, lfsr_seed
    );

    modport slave (
        input  req_val, resp_rdy, seed_val, seed_msg, lfsr_bit,
        output req_rdy, resp_val, resp_msg, seed_rdy, active,
               lfsr_en, lfsr_load, lfsr_seed
    );
endinterface

// File: rtl/random_engine_arbiter.sv
// Round-robin arbiter sharing one serial LFSR among NUM_REQ clients: assembles
// WORD_BITS sampled bits into a word per grant and sequences seed loading.
module random_engine_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WORD_BITS = 16,
    parameter int SEED_BITS = 16
) (
    input logic                    clk,
    input logic                    rst,
    random_engine_arbiter_if.slave bus
);
    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [IDXW-1:0]      r_rr_ptr;
    logic [IDXW-1:0]      r_gnt;
    logic [CNTW-1:0]      r_cnt;
    logic [WORD_BITS-1:0] r_shift;

    logic                 w_found;
    logic [IDXW-1:0]      w_pick;
    logic [IDXW:0]        w_rr_sum;
    logic [IDXW-1:0]      w_rr_idx;

    logic [NUM_REQ-1:0]   w_req_rdy;
    logic [NUM_REQ-1:0]   w_resp_val;
    logic [WORD_BITS-1:0] w_resp_msg;
    logic                 w_seed_rdy;
    logic                 w_active;
    logic                 w_lfsr_en;
    logic                 w_lfsr_load;
    logic [SEED_BITS-1:0] w_lfsr_seed;

    // Round-robin search: first asserted requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_pick   = {IDXW{1'b0}};
        w_rr_sum = {(IDXW+1){1'b0}};
        w_rr_idx = {IDXW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rr_sum = {1'b0, r_rr_ptr} + (IDXW+1)'(i);
            if (w_rr_sum >= (IDXW+1)'(NUM_REQ)) begin
                w_rr_idx = IDXW'(w_rr_sum - (IDXW+1)'(NUM_REQ));
            end else begin
                w_rr_idx = IDXW'(w_rr_sum);
            end
            if (!w_found && bus.req_val[w_rr_idx]) begin
                w_found = 1'b1;
                w_pick  = w_rr_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        w_req_rdy   = {NUM_REQ{1'b0}};
        w_resp_val  = {NUM_REQ{1'b0}};
        w_resp_msg  = {WORD_BITS{1'b0}};
        w_seed_rdy  = 1'b0;
        w_active    = 1'b0;
        w_lfsr_en   = 1'b0;
        w_lfsr_load = 1'b0;
        w_lfsr_seed = {SEED_BITS{1'b0}};
        if (rst) begin
            w_active = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A zero seed would lock the LFSR, so it is replaced by 1.
                    if (bus.seed_val) begin
                        w_seed_rdy  = 1'b1;
                        w_lfsr_load = 1'b1;
                        if (bus.seed_msg == {SEED_BITS{1'b0}}) begin
                            w_lfsr_seed = SEED_BITS'(1);
                        end else begin
                            w_lfsr_seed = bus.seed_msg;
                        end
                    end else if (w_found) begin
                        w_req_rdy[w_pick] = 1'b1;
                    end else begin
                        w_req_rdy = {NUM_REQ{1'b0}};
                    end
                end
                ST_GEN: begin
                    w_lfsr_en = 1'b1;
                    w_active  = 1'b1;
                end
                ST_RESP: begin
                    w_resp_val[r_gnt] = 1'b1;
                    w_resp_msg        = r_shift;
                    w_active          = 1'b1;
                end
                default: begin
                    w_active = 1'b0;
                end
            endcase
        end
    end

    assign bus.req_rdy   = w_req_rdy;
    assign bus.resp_val  = w_resp_val;
    assign bus.resp_msg  = w_resp_msg;
    assign bus.seed_rdy  = w_seed_rdy;
    assign bus.active    = w_active;
    assign bus.lfsr_en   = w_lfsr_en;
    assign bus.lfsr_load = w_lfsr_load;
    assign bus.lfsr_seed = w_lfsr_seed;

    // Control FSM: grant, shift in WORD_BITS bits MSB-first, then hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= {IDXW{1'b0}};
            r_gnt    <= {IDXW{1'b0}};
            r_cnt    <= {CNTW{1'b0}};
            r_shift  <= {WORD_BITS{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.seed_val) begin
                        r_state <= ST_IDLE;
                    end else if (w_found) begin
                        r_gnt   <= w_pick;
                        r_cnt   <= {CNTW{1'b0}};
                        r_state <= ST_GEN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GEN: begin
                    r_shift <= {r_shift[WORD_BITS-2:0], bus.lfsr_bit};
                    r_cnt   <= r_cnt + CNTW'(1);
                    if (r_cnt == CNTW'(WORD_BITS - 1)) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_state <= ST_GEN;
                    end
                end
                ST_RESP: begin
                    if (bus.resp_rdy[r_gnt]) begin
                        if (r_gnt == IDXW'(NUM_REQ - 1)) begin
                            r_rr_ptr <= {IDXW{1'b0}};
                        end else begin
                            r_rr_ptr <= r_gnt + IDXW'(1);
                        end
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_random_engine_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grant order and words;
// a negedge monitor pops and compares every response handshake.
module tb_random_engine_arbiter;
    localparam int NR = 4;
    localparam int WB = 16;
    localparam int SB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    random_engine_arbiter_if #(.NUM_REQ(NR), .WORD_BITS(WB), .SEED_BITS(SB)) bus ();
    random_engine_arbiter #(.NUM_REQ(NR), .WORD_BITS(WB), .SEED_BITS(SB)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Serial LFSR datapath stub driven by the arbiter's control outputs.
    logic [15:0] dp_lfsr = 16'h0001;
    always @(posedge clk) begin
        if (bus.lfsr_load)    dp_lfsr <= bus.lfsr_seed;
        else if (bus.lfsr_en) dp_lfsr <= lfsr_step(dp_lfsr);
    end
    assign bus.lfsr_bit = dp_lfsr[0];

    typedef struct { int idx; logic [WB-1:0] word; } exp_t;
    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] ref_lfsr = 16'h0001;
    int          ref_ptr = 0;

    int   st_rdy_cycles, st_t_acc, st_t_resp, st_en, st_bad, st_wait;
    logic [NR-1:0] st_first_rdy;
    int   st_resp_t[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({bus.req_rdy, bus.resp_val, bus.resp_msg, bus.seed_rdy, bus.active,
                    bus.lfsr_en, bus.lfsr_load, bus.lfsr_seed});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: next grant is the first requester in the mask at/after the pointer;
    // its word is the next WB LFSR output bits, first bit in the MSB.
    task automatic expect_grant(input logic [NR-1:0] mask, output int j);
        exp_t e;
        j = -1;
        for (int k = 0; k < NR; k++) begin
            if (j < 0 && mask[(ref_ptr + k) % NR]) j = (ref_ptr + k) % NR;
        end
        e.idx = j;
        for (int b = 0; b < WB; b++) begin
            e.word[WB-1-b] = ref_lfsr[0];
            ref_lfsr = lfsr_step(ref_lfsr);
        end
        q.push_back(e);
        ref_ptr = (j + 1) % NR;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && ((bus.resp_val & bus.resp_rdy) != 4'b0)) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected resp_val=%b required=none", bus.resp_val);
            end else begin
                mon_e = q.pop_front();
                chk("sb_grant", 64'(bus.resp_val), 64'(4'b0001 << mon_e.idx));
                chk("sb_word", 64'(bus.resp_msg), 64'(mon_e.word));
            end
        end
        if (!rst && (bus.req_rdy != 4'b0 || bus.resp_val != 4'b0))
            chk("onehot", 64'({$countones(bus.req_rdy) <= 1, $countones(bus.resp_val) <= 1}), 64'(2'b11));
    end

    task automatic do_seed(input logic [15:0] s, output int t_acc);
        logic [15:0] exp_s;
        int ok;
        exp_s = (s == 16'h0) ? 16'h0001 : s;
        ok = 0;
        t_acc = -1;
        bus.seed_val = 1'b1;
        bus.seed_msg = s;
        for (int c = 0; c < 200 && ok == 0; c++) begin
            @(negedge clk);
            if (bus.seed_rdy) begin
                ok = 1;
                t_acc = cyc;
                chk("seed_load", 64'(bus.lfsr_load), 64'(1'b1));
                chk("seed_value", 64'(bus.lfsr_seed), 64'(exp_s));
                chk("seed_active", 64'(bus.active), 64'(1'b0));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("seed_accept", 64'(ok), 64'(1));
        step();
        bus.seed_val = 1'b0;
        ref_lfsr = exp_s;
    endtask

    // mode 0: resp_rdy all ones, 1: random, 2: low for 10 waiting cycles then high.
    task automatic run_round(input logic [NR-1:0] mask, input int mode, input int hold_n);
        int n, j, done, wait_cnt;
        logic [NR-1:0] m, hs_req, hs_resp, held_val;
        logic [WB-1:0] held;
        n = (hold_n > 0) ? hold_n : $countones(mask);
        m = mask;
        for (int k = 0; k < n; k++) begin
            expect_grant(m, j);
            if (hold_n == 0) m[j] = 1'b0;
        end
        st_rdy_cycles = 0; st_t_acc = -1; st_t_resp = -1; st_en = 0; st_bad = 0;
        st_first_rdy = '0; st_resp_t.delete();
        wait_cnt = 0; done = 0; held = '0; held_val = '0;
        bus.req_val  = mask;
        bus.resp_rdy = (mode == 0) ? 4'hF : (mode == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        for (int c = 0; c < 1000 && done < n; c++) begin
            @(negedge clk);
            hs_req  = bus.req_val & bus.req_rdy;
            hs_resp = bus.resp_val & bus.resp_rdy;
            if (bus.req_rdy != 4'b0) begin
                st_rdy_cycles++;
                if (st_t_acc < 0) begin st_t_acc = cyc; st_first_rdy = bus.req_rdy; end
            end
            if (bus.lfsr_en) st_en++;
            if (bus.resp_val != 4'b0 && st_t_resp < 0) st_t_resp = cyc;
            if (hs_resp != 4'b0) st_resp_t.push_back(cyc);
            if (mode == 2 && bus.resp_val != 4'b0 && hs_resp == 4'b0) begin
                if (wait_cnt == 0) begin
                    held = bus.resp_msg;
                    held_val = bus.resp_val;
                end else if (bus.resp_msg !== held || bus.resp_val !== held_val) begin
                    st_bad++;
                end
                if (bus.lfsr_en) st_bad++;
                wait_cnt++;
            end
            step();
            if (hs_resp != 4'b0) done++;
            if (hold_n == 0) bus.req_val = bus.req_val & ~hs_req;
            if (mode == 1)      bus.resp_rdy = 4'($urandom_range(0, 15));
            else if (mode == 2) bus.resp_rdy = (wait_cnt >= 10) ? 4'hF : 4'h0;
        end
        st_wait = wait_cnt;
        chk("round_done", 64'(done), 64'(n));
        bus.req_val  = 4'h0;
        bus.resp_rdy = 4'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_async_zero", outs_vec(), 64'h0);
        step();
        step();
        rst = 1'b0;
        bus.seed_val = 1'b0;
        bus.req_val  = 4'h0;
        ref_ptr = 0;
        @(negedge clk);
        chk("idle_after_reset", outs_vec(), 64'h0);
        step();
    endtask

    task automatic wait_drain();
        int ok;
        ok = 0;
        bus.resp_rdy = 4'hF;
        for (int c = 0; c < 200 && ok == 0; c++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.active) ok = 1;
            step();
        end
        chk("drain", 64'(ok), 64'(1));
        bus.resp_rdy = 4'h0;
    endtask

    initial begin
        int t_req, t_seed, dummy;
        logic [NR-1:0] mask;
        bus.req_val = 4'hF; bus.resp_rdy = 4'h0;
        bus.seed_val = 1'b1; bus.seed_msg = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs_vec(), 64'h0);
        rst = 1'b0;
        bus.req_val = 4'h0; bus.seed_val = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", outs_vec(), 64'h0);
        step();

        // Seed 0xACE1, then a single request from requester 2.
        do_seed(16'hACE1, dummy);
        run_round(4'b0100, 0, 0);
        chk("t1_req_rdy", 64'(st_first_rdy), 64'(4'b0100));
        chk("t1_rdy_cycles", 64'(st_rdy_cycles), 64'(1));
        chk("t1_lfsr_en_cycles", 64'(st_en), 64'(16));
        chk("t1_resp_latency", 64'(st_t_resp - st_t_acc), 64'(17));

        // All four held high from a fresh reset: 0,1,2,3,0 at 18-cycle spacing.
        do_reset();
        do_seed(16'h1D2B, dummy);
        run_round(4'b1111, 0, 5);
        chk("t2_resp_count", 64'(st_resp_t.size()), 64'(5));
        for (int k = 1; k < st_resp_t.size(); k++)
            chk("t2_spacing", 64'(st_resp_t[k] - st_resp_t[k-1]), 64'(18));

        // Back-pressure for 10 cycles in RESP.
        run_round(4'b0010, 2, 0);
        chk("t3_wait_cycles", 64'(st_wait), 64'(10));
        chk("t3_stable_no_en", 64'(st_bad), 64'(0));
        @(negedge clk);
        chk("t3_done_idle", 64'({bus.resp_val, bus.active}), 64'(0));
        step();

        // Zero seed is replaced by 1.
        do_seed(16'h0000, dummy);

        // Seed request while busy waits until the arbiter returns to IDLE.
        bus.resp_rdy = 4'hF;
        bus.req_val = 4'b0001;
        expect_grant(4'b0001, dummy);
        @(negedge clk);
        chk("t5_req_rdy", 64'(bus.req_rdy), 64'(4'b0001));
        t_req = cyc;
        step();
        bus.req_val = 4'h0;
        step();
        do_seed(16'h1234, t_seed);
        chk("t5_seed_delay", 64'(t_seed - t_req), 64'(18));
        wait_drain();

        // Seed and request in the same IDLE cycle: seed first, grant next cycle.
        bus.seed_val = 1'b1; bus.seed_msg = 16'h3C3C; bus.req_val = 4'b0010;
        @(negedge clk);
        chk("t6_seed_rdy", 64'({bus.seed_rdy, bus.lfsr_load, bus.req_rdy}), 64'({2'b11, 4'b0000}));
        chk("t6_seed_value", 64'(bus.lfsr_seed), 64'(16'h3C3C));
        ref_lfsr = 16'h3C3C;
        expect_grant(4'b0010, dummy);
        step();
        bus.seed_val = 1'b0;
        @(negedge clk);
        chk("t6_req_rdy_next", 64'(bus.req_rdy), 64'(4'b0010));
        step();
        bus.req_val = 4'h0;
        wait_drain();

        // Reset during GEN cycle 7 with a non-zero round-robin pointer.
        do_seed(16'hBEEF, dummy);
        bus.req_val = 4'b1000;
        @(negedge clk);
        chk("t7_req_rdy", 64'(bus.req_rdy), 64'(4'b1000));
        step();
        bus.req_val = 4'h0;
        repeat (6) step();
        bus.seed_val = 1'b1; bus.req_val = 4'hF; bus.resp_rdy = 4'hF;
        do_reset();
        bus.resp_rdy = 4'h0;
        do_seed(16'h5A5A, dummy);
        run_round(4'b1111, 0, 0);

        // Randomized rounds.
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 1) == 1)
                do_seed(($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), dummy);
            mask = 4'($urandom_range(1, 15));
            run_round(mask, 1, 0);
        end

        repeat (5) step();
        chk("sb_empty", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
